// File: rtl/board_line_clear_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : board_line_clear_ctrl                                      |
// | Description : Post-lock line clear sequencer. Scans the board row store  |
// |               bottom to top, drops full rows, compacts the survivors     |
// |               downward, zero-fills the vacated top rows and reports the  |
// |               number of lines cleared.                                   |
// | Options     : LINE_SCORE_EN - adds a saturating 20-bit score output.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module board_line_clear_ctrl #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int ROW_W   = 16
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(BOARD_H)-1:0]     row_addr,
  output logic                           row_rd_en,
  input  logic [ROW_W-1:0]               row_rdata,
  output logic                           row_wr_en,
  output logic [ROW_W-1:0]               row_wdata,
  output logic [$clog2(BOARD_H+1)-1:0]   lines_cleared,
  output logic [15:0]                    total_lines
`ifdef LINE_SCORE_EN
  ,
  output logic [19:0]                    score
`endif
);

  localparam int AW = $clog2(BOARD_H);
  // Pointers carry one extra bit so stepping below row 0 never aliases a row.
  localparam int PW = AW + 1;
  localparam int CW = $clog2(BOARD_H + 1);
  localparam logic [PW-1:0]    LAST_ROW  = PW'(BOARD_H - 1);
  localparam logic [ROW_W-1:0] LIVE_MASK = ~({ROW_W{1'b1}} << BOARD_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    CHECK = 3'd2,
    FILL  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          row_full;
  logic [CW-1:0] count_next;
  logic [16:0]   total_sum;

  // Only live columns decide fullness; padding bits in the row word are ignored.
  assign row_full   = ((row_rdata & LIVE_MASK) == LIVE_MASK);
  assign count_next = row_full ? count + CW'(1) : count;
  assign total_sum  = {1'b0, total_lines} + 17'(count);

`ifdef LINE_SCORE_EN
  logic [19:0] points;
  logic [20:0] score_sum;

  // Points awarded for one operation, by number of rows removed.
  always_comb begin
    points = 20'd0;
    case (count)
      CW'(0):  points = 20'd0;
      CW'(1):  points = 20'd40;
      CW'(2):  points = 20'd100;
      CW'(3):  points = 20'd300;
      default: points = 20'd1200;
    endcase
  end

  assign score_sum = {1'b0, score} + {1'b0, points};
`endif

  // Write side of the row store: CHECK writes depend on the row returned in
  // that same cycle, so the write strobe, address and data are decoded here.
  always_comb begin
    row_addr  = '0;
    row_wr_en = 1'b0;
    row_wdata = '0;
    case (state)
      READ: begin
        row_addr = rd_ptr[AW-1:0];
      end
      CHECK: begin
        if (!row_full && (wr_ptr != rd_ptr)) begin
          row_wr_en = 1'b1;
          row_addr  = wr_ptr[AW-1:0];
          row_wdata = row_rdata & LIVE_MASK;
        end
      end
      FILL: begin
        row_wr_en = 1'b1;
        row_addr  = wr_ptr[AW-1:0];
      end
      default: ;
    endcase
  end

  // Sequencer: scan pointers, cleared count, status flags and result registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      row_rd_en     <= 1'b0;
      lines_cleared <= '0;
      total_lines   <= '0;
`ifdef LINE_SCORE_EN
      score         <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rd_ptr    <= LAST_ROW;
            wr_ptr    <= LAST_ROW;
            count     <= '0;
            busy      <= 1'b1;
            row_rd_en <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          row_rd_en <= 1'b0;
          state     <= CHECK;
        end
        CHECK: begin
          count <= count_next;
          if (!row_full) begin
            wr_ptr <= wr_ptr - PW'(1);
          end
          if (rd_ptr == '0) begin
            if (count_next != '0) begin
              state <= FILL;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else begin
            rd_ptr    <= rd_ptr - PW'(1);
            row_rd_en <= 1'b1;
            state     <= READ;
          end
        end
        FILL: begin
          wr_ptr <= wr_ptr - PW'(1);
          if (wr_ptr == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done          <= 1'b0;
          busy          <= 1'b0;
          lines_cleared <= count;
          total_lines   <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
`ifdef LINE_SCORE_EN
          score         <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
`endif
          state         <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/board_line_clear_ctrl.md
Name: board_line_clear_ctrl

Overview:
- Sequencer that runs after a piece locks into the playfield board.
- Scans the board row store from bottom to top, removes every full row and compacts the remaining rows downward.
- Zero-fills the vacated top rows, then reports how many lines were cleared.
- Sole owner of the board row-store read/write port while busy; game logic only issues start and waits for done.

Parameters:
BOARD_W, 10, playable columns per row; row bits [BOARD_W-1:0] are live.
BOARD_H, 20, number of rows; row 0 is top, row BOARD_H-1 is bottom.
ROW_W, 16, width of one row word in the row store.

Ports:
Clk  input  1  system clock, all logic on posedge.
Reset_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse from game logic: piece locked, begin scan.
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse, operation complete.
row_addr  output  $clog2(BOARD_H)  row store address.
row_rd_en  output  1  read strobe; row_rdata is valid the following cycle.
row_rdata  input  ROW_W  row word returned by the store.
row_wr_en  output  1  write strobe.
row_wdata  output  ROW_W  row word to write.
lines_cleared  output  $clog2(BOARD_H+1)  full rows removed by the last operation.
total_lines  output  16  running total of cleared lines, saturates at 16'hFFFF.

Behaviour:
- Reset (Reset_n=0, asynchronous): state=IDLE; rd_ptr, wr_ptr and the internal cleared count clear to 0; every output is 0.
- Reset asserted mid-operation aborts immediately with no further writes. Partial board contents are the caller's responsibility.
- States: IDLE, READ, CHECK, FILL, DONE.
- IDLE:
  - start is sampled only here. On start, load rd_ptr=wr_ptr=BOARD_H-1, clear the internal count, go to READ.
  - start seen in any other state, including DONE, is ignored.
- READ: row_rd_en=1, row_addr=rd_ptr, go to CHECK.
- CHECK: row_rdata is valid in this cycle.
  - Full row means row_rdata[BOARD_W-1:0] is all ones; bits above BOARD_W-1 are ignored. On a full row: count+1, wr_ptr unchanged, no write.
  - Non-full row with wr_ptr != rd_ptr: row_wr_en=1, row_addr=wr_ptr, row_wdata = row_rdata with bits above BOARD_W-1 forced to 0. Then wr_ptr-1.
  - Non-full row with wr_ptr == rd_ptr: no write, wr_ptr-1.
  - Next state: if rd_ptr==0, go to FILL when count>0, otherwise DONE. Else rd_ptr-1 and go to READ.
- FILL: one cycle per row. row_wr_en=1, row_addr=wr_ptr, row_wdata=0, wr_ptr-1. Leave for DONE after writing row 0.
- DONE: done=1 for exactly one cycle. lines_cleared<=count; total_lines<=sat(total_lines+count). Return to IDLE.
- Pointers carry one extra bit so decrementing past 0 never wraps into a valid address.
- Latency: start sampled at edge 0. The scan occupies cycles 1..2*BOARD_H, FILL takes count cycles, and done is high in cycle 2*BOARD_H+count+1.
- row_rd_en and row_wr_en are never high in the same cycle. No row store access occurs outside READ, CHECK and FILL.
- lines_cleared and total_lines hold their values between operations.

Optional Feature:
- Macro LINE_SCORE_EN.
- Defined:
  - Adds output score[19:0], reset to 0.
  - In DONE, add per-operation points by count: 0→0, 1→40, 2→100, 3→300, ≥4→1200.
  - score saturates at 20'hFFFFF.
- Undefined: no score port and no score logic; all other behaviour is identical.

Test Plan (BOARD_W=10, BOARD_H=20; a full row is 16'h03FF):
1. Empty board, start pulse → no row_wr_en for the whole operation; done in cycle 41; lines_cleared=0; total_lines=0.
2. Row19=03FF, row18=0001, rest 0 → writes row19←0001, rows18..1←0, then FILL row0←0; done in cycle 42; lines_cleared=1; total_lines=1; score=40 with LINE_SCORE_EN.
3. Rows16..19=03FF, row15=0155 → row19←0155, rows0..3 zero-filled; done in cycle 45; lines_cleared=4; score=1200.
4. Row10=13FF (extra upper bit) and row5=F3FE → row10 counted full, lines_cleared=1; row5 written to row6 as 03FE (upper bits masked).
5. start re-pulsed in cycle 10 and again in the done cycle → both ignored; exactly one done pulse; busy=0 in the cycle after done.
6. Reset_n driven low in cycle 15 of a scan that has full rows → busy, done, row_rd_en and row_wr_en are 0 immediately; total_lines=0; a later start runs a normal scan.
